sf_camera_pwr_seq: RTL
======================

SF_CAMERA_PWR_SEQ -- requirements
Module: sf_camera_pwr_seq

Interface
REQ-001 SHALL have parameter DCM_RST_CYCLES, default 4: cycles dcm_rst held high per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles allowed in WAIT_LOCK.
REQ-003 SHALL have parameter CAM_RST_CYCLES, default 50000: cycles cam_rst_n held low (1 ms at 50 MHz).
REQ-004 SHALL have parameter CAM_SETUP_CYCLES, default 100000: cycles from cam_rst_n release to ready.
REQ-005 SHALL have parameter MAX_RETRY, default 3: failed lock attempts before FAULT.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  level; high requests camera power-up.
REQ-009 dcm_locked  in  1  LOCKED from camera clock generator; asynchronous to clk.
REQ-010 dcm_rst  out  1  RST to camera clock generator, active high.
REQ-011 cam_pwdn  out  1  camera power-down pin, active high.
REQ-012 cam_rst_n  out  1  camera reset pin, active low.
REQ-013 ready  out  1  camera clocked, out of reset, setup time elapsed.
REQ-014 fault  out  1  retries exhausted.
REQ-015 retry_count  out  2  failed lock attempts in current enable session.
REQ-016 state  out  3  current FSM state encoding, for register readback.

Function
REQ-017 dcm_locked SHALL pass a 2-flop synchronizer; all logic SHALL use the synchronized lock (lk).
REQ-018 States SHALL be IDLE, DCM_RST, WAIT_LOCK, CAM_RST, CAM_SETUP, READY, FAULT; one shared down-counter, loaded on each state entry.
REQ-019 IDLE: dcm_rst=1, cam_pwdn=1, cam_rst_n=0, retry_count=0; enable=1 -> DCM_RST.
REQ-020 DCM_RST: dcm_rst=1 for exactly DCM_RST_CYCLES cycles -> WAIT_LOCK.
REQ-021 WAIT_LOCK: dcm_rst=0; lk=1 -> CAM_RST; counter expiry after LOCK_TIMEOUT cycles -> retry_count+1, then DCM_RST if new count < MAX_RETRY, else FAULT.
REQ-022 CAM_RST: cam_pwdn=0, cam_rst_n=0 for CAM_RST_CYCLES cycles -> CAM_SETUP.
REQ-023 CAM_SETUP: cam_rst_n=1 for CAM_SETUP_CYCLES cycles -> READY.
REQ-024 READY: ready=1 combinationally equal to (state==READY); no other state asserts ready.
REQ-025 lk falling in CAM_RST, CAM_SETUP or READY SHALL go to DCM_RST next cycle with cam_rst_n=0, without incrementing retry_count.
REQ-026 FAULT: fault=1, dcm_rst=1, cam_pwdn=1, cam_rst_n=0; exits only via enable=0.
REQ-027 enable=0 in any state SHALL go to IDLE next cycle, priority over all other transitions.
REQ-028 retry_count SHALL saturate at MAX_RETRY, never wrap.
REQ-029 All outputs SHALL be registered except ready/fault/state decode.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, counter=0, retry_count=0, synchronizer flops=0, dcm_rst=1, cam_pwdn=1, cam_rst_n=0, ready=0, fault=0.
REQ-031 Reset deassertion mid-power-up SHALL restart sequence from IDLE; no partial state retained.

Configuration
REQ-032 With SF_CAMERA_PWR_SEQ_LOCK_FILTER_EN defined, WAIT_LOCK SHALL exit only after lk high for 16 consecutive cycles; any low restarts the filter count; timeout unchanged.
REQ-033 Without SF_CAMERA_PWR_SEQ_LOCK_FILTER_EN, the first cycle of lk=1 SHALL exit WAIT_LOCK; no filter counter synthesized.

Structure
REQ-034 Package sf_camera_pkg SHALL hold the state enum (3-bit encoding), default cycle constants and lock-filter length 16.
REQ-035 Synchronizer SHALL be sub-module sf_camera_sync (2-flop, reset to 0); FSM and counters stay in sf_camera_pwr_seq.

Verification (bench params: DCM_RST_CYCLES=4, LOCK_TIMEOUT=20, CAM_RST_CYCLES=10, CAM_SETUP_CYCLES=8, MAX_RETRY=3)
REQ-036 enable=1, dcm_locked high 5 cycles after dcm_rst falls -> cam_rst_n low 10 cycles, high, ready=1 exactly 8 cycles later.
REQ-037 enable=1, dcm_locked never high -> three 20-cycle WAIT_LOCK windows, retry_count 1,2,3, fault=1, dcm_rst=1; enable=0 -> IDLE, retry_count=0.
REQ-038 In READY, drop dcm_locked -> within 3 cycles ready=0, cam_rst_n=0, dcm_rst=1 for 4 cycles; retry_count unchanged.
REQ-039 enable=0 during CAM_SETUP -> IDLE next cycle, cam_pwdn=1, cam_rst_n=0.
REQ-040 rst_n pulsed low in WAIT_LOCK (between clk edges) -> outputs at reset values immediately; with LOCK_FILTER_EN, 10-cycle lock glitch -> no exit from WAIT_LOCK.

Source files
------------

// File: rtl/sf_camera_pkg.sv
// Shared types and default timing constants for the camera power sequencer.
// Lock filter length applies only when SF_CAMERA_PWR_SEQ_LOCK_FILTER_EN is defined.
package sf_camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DCM_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_CAM_RST   = 3'd3,
    ST_CAM_SETUP = 3'd4,
    ST_READY     = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  localparam int DEF_DCM_RST_CYCLES   = 4;
  localparam int DEF_LOCK_TIMEOUT     = 65535;
  localparam int DEF_CAM_RST_CYCLES   = 50000;
  localparam int DEF_CAM_SETUP_CYCLES = 100000;
  localparam int DEF_MAX_RETRY        = 3;
  localparam int LOCK_FILTER_LEN      = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sf_camera_sync.sv
// Two-flop synchronizer for the clock generator LOCKED input; both flops reset to 0.
module sf_camera_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sf_camera_pwr_seq.sv
// Camera power-up sequencer: clock generator reset/lock with retries, then camera reset and setup.
// Define SF_CAMERA_PWR_SEQ_LOCK_FILTER_EN to require a sustained lock before leaving WAIT_LOCK.
module sf_camera_pwr_seq
  import sf_camera_pkg::*;
#(
  parameter int DCM_RST_CYCLES   = DEF_DCM_RST_CYCLES,
  parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int CAM_RST_CYCLES   = DEF_CAM_RST_CYCLES,
  parameter int CAM_SETUP_CYCLES = DEF_CAM_SETUP_CYCLES,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       dcm_locked,
  output logic       dcm_rst,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state
);

  localparam int MAX_CYC = max2(max2(DCM_RST_CYCLES, LOCK_TIMEOUT),
                                max2(CAM_RST_CYCLES, CAM_SETUP_CYCLES));
  localparam int CW = $clog2(MAX_CYC + 1);
  typedef logic [CW-1:0] cnt_t;

  // Counter is loaded with N-1 so a state lasts exactly N cycles.
  localparam cnt_t LD_DCM   = cnt_t'(DCM_RST_CYCLES - 1);
  localparam cnt_t LD_LOCK  = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t LD_CRST  = cnt_t'(CAM_RST_CYCLES - 1);
  localparam cnt_t LD_SETUP = cnt_t'(CAM_SETUP_CYCLES - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  logic       lk;
  logic       lock_ok;
  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] retry_q, retry_d;
  logic       dcm_rst_q, dcm_rst_d;
  logic       cam_pwdn_q, cam_pwdn_d;
  logic       cam_rst_n_q, cam_rst_n_d;
  logic       cnt_done;

  sf_camera_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dcm_locked),
    .q     (lk)
  );

  assign cnt_done = (cnt_q == '0);

`ifdef SF_CAMERA_PWR_SEQ_LOCK_FILTER_EN
  localparam int FW = $clog2(LOCK_FILTER_LEN);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER_LEN - 1);
  logic [FW-1:0] filt_q, filt_d;

  // Counts consecutive lk-high cycles in WAIT_LOCK; any low cycle clears it.
  always_comb begin
    filt_d = '0;
    if (state_q == ST_WAIT_LOCK && lk)
      filt_d = (filt_q == FILT_LAST) ? filt_q : filt_q + FW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_q <= '0;
    else        filt_q <= filt_d;
  end

  assign lock_ok = lk && (filt_q == FILT_LAST);
`else
  assign lock_ok = lk;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_done ? cnt_q : cnt_q - cnt_t'(1);
    retry_d = retry_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DCM_RST;
          cnt_d   = LD_DCM;
          retry_d = '0;
        end
        ST_DCM_RST: if (cnt_done) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = LD_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_ok) begin
            state_d = ST_CAM_RST;
            cnt_d   = LD_CRST;
          end else if (cnt_done) begin
            retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + 2'd1;
            if (retry_d < RETRY_MAX) begin
              state_d = ST_DCM_RST;
              cnt_d   = LD_DCM;
            end else begin
              state_d = ST_FAULT;
              cnt_d   = '0;
            end
          end
        end
        // Lock loss after WAIT_LOCK is a relock, not a failed attempt.
        ST_CAM_RST: begin
          if (!lk) begin
            state_d = ST_DCM_RST;
            cnt_d   = LD_DCM;
          end else if (cnt_done) begin
            state_d = ST_CAM_SETUP;
            cnt_d   = LD_SETUP;
          end
        end
        ST_CAM_SETUP: begin
          if (!lk) begin
            state_d = ST_DCM_RST;
            cnt_d   = LD_DCM;
          end else if (cnt_done) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end
        end
        ST_READY: if (!lk) begin
          state_d = ST_DCM_RST;
          cnt_d   = LD_DCM;
        end
        ST_FAULT: state_d = ST_FAULT;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pin outputs are decoded from the next state so they register in step with state_q.
  always_comb begin
    dcm_rst_d   = (state_d inside {ST_IDLE, ST_DCM_RST, ST_FAULT});
    cam_pwdn_d  = (state_d inside {ST_IDLE, ST_DCM_RST, ST_WAIT_LOCK, ST_FAULT});
    cam_rst_n_d = (state_d inside {ST_CAM_SETUP, ST_READY});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      dcm_rst_q   <= 1'b1;
      cam_pwdn_q  <= 1'b1;
      cam_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      dcm_rst_q   <= dcm_rst_d;
      cam_pwdn_q  <= cam_pwdn_d;
      cam_rst_n_q <= cam_rst_n_d;
    end
  end

  assign dcm_rst     = dcm_rst_q;
  assign cam_pwdn    = cam_pwdn_q;
  assign cam_rst_n   = cam_rst_n_q;
  assign retry_count = retry_q;
  assign ready       = (state_q == ST_READY);
  assign fault       = (state_q == ST_FAULT);
  assign state       = state_q;

endmodule
